// File: rtl/rffp_conv_arbiter.sv
// rffp_conv_arbiter: round-robin share of one bfloat16-to-RFFP converter
// among NUM_REQ valid/ready requesters, feeding a single registered output
// slot tagged with the winning requester id.
module rffp_conv_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FP_WIDTH       = 16,
  parameter int MANTISSA_WIDTH = 7,
  parameter int RFFP_EXP_WIDTH = 8,
  parameter int RFFP_MAN_WIDTH = 7,
  parameter int EXPONENT_BIAS  = 75,
  parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*FP_WIDTH-1:0]            req_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] out_data,
  output logic [ID_WIDTH-1:0]                    out_id,
  output logic [15:0]                            conv_count
);

  localparam int OUT_W  = RFFP_EXP_WIDTH + RFFP_MAN_WIDTH + 1;
  localparam int E_IN_W = FP_WIDTH - 1 - MANTISSA_WIDTH;
  localparam int SHIFT  = 7 - RFFP_MAN_WIDTH;

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] cand;
  logic                found;
  logic                load_en;
  logic                xfer;
  logic [FP_WIDTH-1:0] sel_data;
  int                  idx;

  // Rebias the exponent (modulo wrap) and truncate the mantissa.
  function automatic logic [OUT_W-1:0] convert(input logic [FP_WIDTH-1:0] w);
    logic                      s;
    logic [E_IN_W-1:0]         e;
    logic [MANTISSA_WIDTH-1:0] m;
    int                        ex;
    s = w[FP_WIDTH-1];
    e = w[FP_WIDTH-2:MANTISSA_WIDTH];
    m = w[MANTISSA_WIDTH-1:0];
    if (e == '0)
      ex = 0;
    else if (RFFP_EXP_WIDTH == 6)
      ex = int'(e) - EXPONENT_BIAS + SHIFT;
    else
      ex = int'(e) - (128 - (1 << (RFFP_EXP_WIDTH - 1))) + SHIFT;
    return {s, RFFP_EXP_WIDTH'(ex), RFFP_MAN_WIDTH'(m >> SHIFT)};
  endfunction

  assign load_en = !out_valid || out_ready;

  // Circular search for the first valid requester after rr_ptr.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_WIDTH'(idx);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Grants are only exposed when the slot can load and reset is released.
  assign req_ready = (load_en && rst_n) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign sel_data  = req_data[grant_id*FP_WIDTH +: FP_WIDTH];

  // Output slot, round-robin pointer and saturating transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      conv_count <= '0;
      rr_ptr     <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= convert(sel_data);
        out_id    <= grant_id;
        rr_ptr    <= grant_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && conv_count != 16'hFFFF)
        conv_count <= conv_count + 16'd1;
    end
  end

endmodule
